sms_phase_gen: RTL and testbench

Parametrised timing-ring generator for the SDTRL clock path. It takes the single master oscillator clock and produces an N-phase, non-overlapping, one-hot phase ring with a programmable per-phase dwell. It also provides a binary-trigger output that toggles once per ring cycle, and run, stop and single-step control that always stops on a cycle boundary. It replaces the fixed oscillator, binary trigger and 2-way inverter chain that feeds the CPU timing cards.

---
 rtl/sms_phase_gen.sv | 138 +++++++++++++
 tb/tb_sms_phase_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_phase_gen.sv
// sms_phase_gen: N-phase, non-overlapping, one-hot timing ring driven from the master oscillator.
//
// Each phase dwells div+1 clocks. The ring free-runs while run is high and stops only on a cycle
// boundary. While stopped, a rising edge on step runs exactly one ring cycle. trig toggles once
// per completed ring cycle, and trig_n is its registered complement.
//
// Ports:
//   clk        master oscillator clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   div        dwell control; each phase lasts div+1 clocks
//   run        level; 1 = free-run, 0 = stop at the next cycle boundary
//   step       a rising edge requests one ring cycle while stopped
//   phase      one-hot active phase; all-zero when stopped
//   trig       binary trigger; toggles at each completed ring cycle
//   trig_n     complement of trig
//   cycle_end  one-clock pulse on the last clock of the last phase
//   running    high while a ring cycle is in progress
module sms_phase_gen #(
    parameter int unsigned PHASES = 2,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              run,
    input  logic              step,
    output logic [PHASES-1:0] phase,
    output logic              trig,
    output logic              trig_n,
    output logic              cycle_end,
    output logic              running
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

    localparam logic [PHASES-1:0] PhaseFirst = PHASES'(1);
    localparam logic [DIV_W-1:0]  CntOne     = DIV_W'(1);

    state_e             state_q, state_d;
    logic [PHASES-1:0]  phase_q, phase_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               trig_q, trig_d;
    logic               trig_n_q;
    logic               step_q;
    logic               cycle_end_q, cycle_end_d;
    logic               running_q, running_d;
    logic               step_edge;

    // Step edges are only acted on in StIdle, so edges seen while a cycle is in progress are
    // dropped rather than queued.
    assign step_edge = step & ~step_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                    phase_d = PhaseFirst;
                    cnt_d   = div;
                end else if (step_edge) begin
                    state_d = StStep;
                    phase_d = PhaseFirst;
                    cnt_d   = div;
                end
            end

            StRun, StStep: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else if (!phase_q[PHASES-1]) begin
                    // div is captured on the edge that enters each phase, so a mid-phase change
                    // only affects the following phase.
                    phase_d = phase_q << 1;
                    cnt_d   = div;
                end else begin
                    // Cycle boundary: the only place run is consulted.
                    trig_d = ~trig_q;
                    if ((state_q == StRun) && run) begin
                        phase_d = PhaseFirst;
                        cnt_d   = div;
                    end else begin
                        state_d = StIdle;
                        phase_d = '0;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Registered look-ahead: high for the clock in which the last phase is on its final count.
        cycle_end_d = phase_d[PHASES-1] & (cnt_d == '0);
        running_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            trig_n_q    <= 1'b1;
            step_q      <= 1'b0;
            cycle_end_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            trig_n_q    <= ~trig_d;
            step_q      <= step;
            cycle_end_q <= cycle_end_d;
            running_q   <= running_d;
        end
    end

    assign phase     = phase_q;
    assign trig      = trig_q;
    assign trig_n    = trig_n_q;
    assign cycle_end = cycle_end_q;
    assign running   = running_q;

endmodule

// File: tb/tb_sms_phase_gen.sv
// Testbench for sms_phase_gen. Three instances (PHASES = 2, 3, 4) share one set of inputs and
// are checked every clock against a behavioural model that tracks phase index and remaining
// dwell clocks. A table of hand-derived vectors and a few directed sequences add fixed checks.
module tb_sms_phase_gen;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] div   = 4'd0;
    logic       run   = 1'b0;
    logic       step  = 1'b0;

    logic [1:0] ph2;
    logic [2:0] ph3;
    logic [3:0] ph4;
    logic [2:0] trig_v, trig_n_v, ce_v, run_v;
    logic [15:0] d_ph [3];

    assign d_ph[0] = {14'b0, ph2};
    assign d_ph[1] = {13'b0, ph3};
    assign d_ph[2] = {12'b0, ph4};

    sms_phase_gen #(.PHASES(2), .DIV_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .div(div), .run(run), .step(step), .phase(ph2),
        .trig(trig_v[0]), .trig_n(trig_n_v[0]), .cycle_end(ce_v[0]), .running(run_v[0])
    );
    sms_phase_gen #(.PHASES(3), .DIV_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .div(div), .run(run), .step(step), .phase(ph3),
        .trig(trig_v[1]), .trig_n(trig_n_v[1]), .cycle_end(ce_v[1]), .running(run_v[1])
    );
    sms_phase_gen #(.PHASES(4), .DIV_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .div(div), .run(run), .step(step), .phase(ph4),
        .trig(trig_v[2]), .trig_n(trig_n_v[2]), .cycle_end(ce_v[2]), .running(run_v[2])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per instance, whether a cycle is active, whether it is a single step,
    // the active phase index, clocks remaining in that phase, and the trigger level.
    bit model_on = 1'b0;
    bit m_act [3];
    bit m_stepm [3];
    int m_idx [3];
    int m_rem [3];
    bit m_trig [3];
    bit m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_act[k]   <= 1'b0;
                m_stepm[k] <= 1'b0;
                m_idx[k]   <= 0;
                m_rem[k]   <= 0;
                m_trig[k]  <= 1'b0;
            end
            m_prev <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                automatic int p = k + 2;
                automatic bit a = m_act[k];
                automatic bit s = m_stepm[k];
                automatic int i = m_idx[k];
                automatic int r = m_rem[k];
                automatic bit t = m_trig[k];
                if (!a) begin
                    if (run || (step && !m_prev)) begin
                        a = 1'b1;
                        s = !run;
                        i = 0;
                        r = int'(div) + 1;
                    end
                end else if (r > 1) begin
                    r = r - 1;
                end else if (i < p - 1) begin
                    i = i + 1;
                    r = int'(div) + 1;
                end else begin
                    t = !t;
                    if (!s && run) begin
                        i = 0;
                        r = int'(div) + 1;
                    end else begin
                        a = 1'b0;
                        i = 0;
                        r = 0;
                    end
                end
                m_act[k]   <= a;
                m_stepm[k] <= s;
                m_idx[k]   <= i;
                m_rem[k]   <= r;
                m_trig[k]  <= t;
            end
            m_prev <= step;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 3; k++) begin
                automatic logic [15:0] e_ph = m_act[k] ? (16'd1 << m_idx[k]) : 16'd0;
                automatic logic e_ce = m_act[k] && (m_idx[k] == k + 1) && (m_rem[k] == 1);
                chk($sformatf("model_p%0d", k + 2),
                    {12'b0, d_ph[k], trig_v[k], trig_n_v[k], ce_v[k], run_v[k]},
                    {12'b0, e_ph, m_trig[k], ~m_trig[k], e_ce, m_act[k]});
            end
        end
    end

    typedef struct {
        logic       run;
        logic       step;
        logic [3:0] div;
        logic [3:0] ph;
        logic       trig;
        logic       ce;
        logic       rn;
    } vec_t;

    vec_t tbl [18];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ph4(input logic [3:0] want, input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (ph4 == want) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    bit found;
    int c1, c2, ce_cnt, tog_cnt, run_cnt;
    logic prev_trig;
    logic step_sched [12];

    initial begin
        // PHASES = 4 instance, applied before each edge, expected just after it.
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 4'd0, 4'b0100, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 4'b0010, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'd0, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 4'b1000, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 4'd1, 4'b0100, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'd1, 4'b0100, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 4'd1, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 4'd1, 4'b1000, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 4'd1, 4'b0000, 1'b1, 1'b0, 1'b0};

        // Reset state.
        #12;
        chk("rst_phase4", 32'(ph4), 32'd0);
        chk("rst_phase2", 32'(ph2), 32'd0);
        chk("rst_trig", 32'(trig_v), 32'd0);
        chk("rst_trig_n", 32'(trig_n_v), 32'd7);
        chk("rst_ce", 32'(ce_v), 32'd0);
        chk("rst_running", 32'(run_v), 32'd0);
        rst_n    = 1'b1;
        model_on = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run  = tbl[i].run;
            step = tbl[i].step;
            div  = tbl[i].div;
            tick();
            chk($sformatf("tbl%0d_phase", i), 32'(ph4), 32'(tbl[i].ph));
            chk($sformatf("tbl%0d_trig", i), 32'(trig_v[2]), 32'(tbl[i].trig));
            chk($sformatf("tbl%0d_ce", i), 32'(ce_v[2]), 32'(tbl[i].ce));
            chk($sformatf("tbl%0d_running", i), 32'(run_v[2]), 32'(tbl[i].rn));
        end

        // div 1 -> 3 during the first clock of phase[1].
        run = 1'b1;
        div = 4'd1;
        wait_ph4(4'b0010, "divchg_wait", found);
        if (found) begin
            div = 4'd3;
            c1 = 1;
            c2 = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (ph4 == 4'b0010) c1++;
                if (ph4 == 4'b0100) c2++;
            end
            chk("divchg_cur_len", 32'(c1), 32'd2);
            chk("divchg_next_len", 32'(c2), 32'd4);
        end

        // Drop run during phase[1]; the cycle must still complete.
        wait_ph4(4'b0010, "stop_wait", found);
        if (found) begin
            run = 1'b0;
            prev_trig = trig_v[2];
            c1 = 0;
            c2 = 0;
            ce_cnt = 0;
            tog_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (ph4 == 4'b0100) c1++;
                if (ph4 == 4'b1000) c2++;
                if (ce_v[2]) ce_cnt++;
                if (trig_v[2] != prev_trig) tog_cnt++;
                prev_trig = trig_v[2];
            end
            chk("stop_ph2_len", 32'(c1), 32'd4);
            chk("stop_ph3_len", 32'(c2), 32'd4);
            chk("stop_ce_count", 32'(ce_cnt), 32'd1);
            chk("stop_trig_toggles", 32'(tog_cnt), 32'd1);
            chk("stop_phase", 32'(ph4), 32'd0);
            chk("stop_running", 32'(run_v[2]), 32'd0);
        end

        // Single step on PHASES = 3 with div = 1: 5-clock step pulse, then a second rising
        // edge on the cycle's last clock that must be discarded.
        div = 4'd1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (run_v == 3'b000) found = 1'b1;
        end
        chk("step_idle_wait", 32'(found), 32'd1);
        step_sched = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step = step_sched[i];
            tick();
            if (run_v[1]) run_cnt++;
        end
        chk("step_one_cycle", 32'(run_cnt), 32'd6);
        chk("step_ends_idle", 32'(ph3), 32'd0);
        run_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i == 0);
            tick();
            if (run_v[1]) run_cnt++;
        end
        chk("step_again", 32'(run_cnt), 32'd6);

        // Asynchronous reset in the middle of phase[2].
        run = 1'b1;
        div = 4'd3;
        wait_ph4(4'b0100, "arst_wait", found);
        if (found) begin
            #1 rst_n = 1'b0;
            #1;
            chk("arst_phase", 32'(ph4), 32'd0);
            chk("arst_trig", 32'(trig_v[2]), 32'd0);
            chk("arst_trig_n", 32'(trig_n_v[2]), 32'd1);
            chk("arst_running", 32'(run_v[2]), 32'd0);
            chk("arst_ce", 32'(ce_v[2]), 32'd0);
        end
        rst_n = 1'b0;
        div = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_restart_phase", 32'(ph4), 32'd1);
        chk("arst_restart_running", 32'(run_v[2]), 32'd1);
        // PHASES = 2, div = 0 free-run pattern from a clean reset.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p2_phase%0d", i), 32'(ph2), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("p2_ce%0d", i), 32'(ce_v[0]), 32'(i % 2));
            chk($sformatf("p2_trig%0d", i), 32'(trig_v[0]), 32'((i / 2) % 2));
            tick();
        end

        // Randomised run/step/div traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            run  = ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 8 : 2));
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) div = 4'($urandom_range(0, 3));
            tick();
        end

        model_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
